// File: rtl/datapath_controller_mc.sv
// rtl/datapath_controller_mc.sv - multicycle controller sequencing one instruction through EXEC/MEM/MDU/WB
// with stalls on memory wait-states and the MDU, and traps for illegal, misaligned and timed-out accesses.
module datapath_controller_mc #(
   parameter int RV_EXT_M       = 1,
   parameter int MEM_TIMEOUT    = 16,
   parameter int MISALIGN_CHECK = 1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [31:0] i_inst,
   input  logic        i_instValid,
   output logic        o_instReady,
   input  logic        i_isEqual,
   input  logic        i_isLessSigned,
   input  logic        i_isLessUnsigned,
   input  logic [1:0]  i_addrLow,
   input  logic        i_memReady,
   input  logic        i_mduDone,
   input  logic        i_trapAck,
   output logic        o_memRdEnable,
   output logic        o_memWrEnable,
   output logic [1:0]  o_memAccess,
   output logic        o_memUnsigned,
   output logic [3:0]  o_aluControl,
   output logic [2:0]  o_mduControl,
   output logic        o_mduStart,
   output logic [1:0]  o_operandASel,
   output logic [1:0]  o_operandBSel,
   output logic        o_regWrEnable,
   output logic [1:0]  o_regWrDataSel,
   output logic        o_pcUpdate,
   output logic [1:0]  o_pcNextSel,
   output logic        o_trap,
   output logic [1:0]  o_trapCause
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_MEM, S_MDU, S_WB, S_TRAP
   } state_t;

   state_t          r_state, w_stateNext;
   logic [31:0]     r_inst;
   logic [CW-1:0]   r_count;
   logic [1:0]      r_trapCause, w_trapCauseNext;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic            w_illegal, w_isMdu, w_branchTaken, w_misaligned, w_timeout;
   logic [CW-1:0]   w_countInc;
   logic            w_unused;

   assign w_opcode   = r_inst[6:0];
   assign w_funct3   = r_inst[14:12];
   assign w_funct7   = r_inst[31:25];
   assign w_countInc = r_count + 1'b1;
   assign w_timeout  = (MEM_TIMEOUT > 0) && (w_countInc == CW'(MEM_TIMEOUT));
   assign w_unused   = ^{r_inst[24:15], r_inst[11:7]};

   assign w_misaligned = (MISALIGN_CHECK != 0) &&
                         (((w_funct3[1:0] == 2'b01) && i_addrLow[0]) ||
                          ((w_funct3[1:0] == 2'b10) && (i_addrLow != 2'b00)));

   always_comb begin
      w_illegal = 1'b0;
      w_isMdu   = 1'b0;
      case (w_opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: w_illegal = 1'b0;
         OPC_JALR:   w_illegal = (w_funct3 != 3'b000);
         OPC_BRANCH: w_illegal = (w_funct3[2:1] == 2'b01);
         OPC_LOAD:   w_illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
         OPC_STORE:  w_illegal = w_funct3[2] || (w_funct3[1:0] == 2'b11);
         OPC_OPIMM: begin
            if (w_funct3 == 3'b001)
               w_illegal = (w_funct7 != 7'b0000000);
            else if (w_funct3 == 3'b101)
               w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
         end
         OPC_OP: begin
            if (w_funct7 == 7'b0000000)
               w_illegal = 1'b0;
            else if ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))
               w_illegal = 1'b0;
            else if ((w_funct7 == 7'b0000001) && (RV_EXT_M != 0))
               w_isMdu = 1'b1;
            else
               w_illegal = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // BGE/BGEU count equality as taken even when the less flag is set
   always_comb begin
      case (w_funct3)
         3'b000:  w_branchTaken = i_isEqual;
         3'b001:  w_branchTaken = !i_isEqual;
         3'b100:  w_branchTaken = i_isLessSigned;
         3'b101:  w_branchTaken = !i_isLessSigned || i_isEqual;
         3'b110:  w_branchTaken = i_isLessUnsigned;
         3'b111:  w_branchTaken = !i_isLessUnsigned || i_isEqual;
         default: w_branchTaken = 1'b0;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_inst      <= 32'd0;
         r_count     <= '0;
         r_trapCause <= CAUSE_ILLEGAL;
      end else begin
         r_state     <= w_stateNext;
         r_trapCause <= w_trapCauseNext;
         if (r_state == S_IDLE && i_instValid)
            r_inst <= i_inst;
         r_count <= (r_state == S_MEM && w_stateNext == S_MEM) ? w_countInc : '0;
      end
   end

   always_comb begin
      w_stateNext     = r_state;
      w_trapCauseNext = r_trapCause;
      o_instReady     = 1'b0;
      o_memRdEnable   = 1'b0;
      o_memWrEnable   = 1'b0;
      o_memAccess     = 2'b00;
      o_memUnsigned   = 1'b0;
      o_aluControl    = ALU_ADD;
      o_mduControl    = 3'b000;
      o_mduStart      = 1'b0;
      o_operandASel   = 2'b00;
      o_operandBSel   = 2'b00;
      o_regWrEnable   = 1'b0;
      o_regWrDataSel  = 2'b00;
      o_pcUpdate      = 1'b0;
      o_pcNextSel     = 2'b00;
      o_trap          = 1'b0;
      o_trapCause     = 2'b00;
      case (r_state)
         S_IDLE: begin
            o_instReady = 1'b1;
            if (i_instValid)
               w_stateNext = S_EXEC;
         end
         S_EXEC: begin
            w_stateNext = S_IDLE;
            if (w_illegal) begin
               w_stateNext     = S_TRAP;
               w_trapCauseNext = CAUSE_ILLEGAL;
            end else begin
               case (w_opcode)
                  OPC_LUI, OPC_AUIPC: begin
                     o_operandASel = (w_opcode == OPC_LUI) ? 2'b10 : 2'b01;
                     o_operandBSel = 2'b01;
                     o_regWrEnable = 1'b1;
                     o_pcUpdate    = 1'b1;
                  end
                  OPC_OP: begin
                     if (w_isMdu) begin
                        o_mduStart   = 1'b1;
                        o_mduControl = w_funct3;
                        w_stateNext  = S_MDU;
                     end else begin
                        o_aluControl  = {r_inst[30], w_funct3};
                        o_regWrEnable = 1'b1;
                        o_pcUpdate    = 1'b1;
                     end
                  end
                  OPC_OPIMM: begin
                     // only the shift-right immediate carries the arithmetic bit
                     o_aluControl  = {(w_funct3 == 3'b101) && r_inst[30], w_funct3};
                     o_operandBSel = 2'b01;
                     o_regWrEnable = 1'b1;
                     o_pcUpdate    = 1'b1;
                  end
                  OPC_JAL, OPC_JALR: begin
                     o_operandASel  = (w_opcode == OPC_JAL) ? 2'b01 : 2'b00;
                     o_operandBSel  = 2'b01;
                     o_regWrEnable  = 1'b1;
                     o_regWrDataSel = 2'b10;
                     o_pcUpdate     = 1'b1;
                     o_pcNextSel    = (w_opcode == OPC_JAL) ? 2'b01 : 2'b11;
                  end
                  OPC_BRANCH: begin
                     o_pcUpdate  = 1'b1;
                     o_pcNextSel = w_branchTaken ? 2'b01 : 2'b00;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     o_operandBSel = 2'b01;
                     if (w_misaligned) begin
                        w_stateNext     = S_TRAP;
                        w_trapCauseNext = CAUSE_MISALIGN;
                     end else begin
                        w_stateNext = S_MEM;
                     end
                  end
                  default: begin
                     w_stateNext     = S_TRAP;
                     w_trapCauseNext = CAUSE_ILLEGAL;
                  end
               endcase
            end
         end
         S_MEM: begin
            o_operandBSel = 2'b01;
            o_memRdEnable = (w_opcode == OPC_LOAD);
            o_memWrEnable = (w_opcode == OPC_STORE);
            o_memAccess   = w_funct3[1:0];
            o_memUnsigned = w_funct3[2];
            if (i_memReady) begin
               if (w_opcode == OPC_LOAD) begin
                  w_stateNext = S_WB;
               end else begin
                  o_pcUpdate  = 1'b1;
                  w_stateNext = S_IDLE;
               end
            end else if (w_timeout) begin
               w_stateNext     = S_TRAP;
               w_trapCauseNext = CAUSE_TIMEOUT;
            end
         end
         S_MDU: begin
            o_mduControl = w_funct3;
            if (i_mduDone)
               w_stateNext = S_WB;
         end
         S_WB: begin
            o_regWrEnable  = 1'b1;
            o_regWrDataSel = (w_opcode == OPC_LOAD) ? 2'b01 : 2'b11;
            o_pcUpdate     = 1'b1;
            w_stateNext    = S_IDLE;
         end
         S_TRAP: begin
            o_trap      = 1'b1;
            o_trapCause = r_trapCause;
            if (i_trapAck)
               w_stateNext = S_IDLE;
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_datapath_controller_mc.sv
// tb/tb_datapath_controller_mc.sv - table-driven bench for datapath_controller_mc plus multicycle sequences
module tb_datapath_controller_mc;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] i_inst = 32'd0;
   logic        i_instValid = 1'b0;
   logic        i_isEqual = 1'b0, i_isLessSigned = 1'b0, i_isLessUnsigned = 1'b0;
   logic [1:0]  i_addrLow = 2'b00;
   logic        i_memReady = 1'b0, i_mduDone = 1'b0, i_trapAck = 1'b0;

   logic        o_instReady, o_memRdEnable, o_memWrEnable, o_memUnsigned, o_mduStart;
   logic        o_regWrEnable, o_pcUpdate, o_trap;
   logic [1:0]  o_memAccess, o_operandASel, o_operandBSel, o_regWrDataSel, o_pcNextSel, o_trapCause;
   logic [3:0]  o_aluControl;
   logic [2:0]  o_mduControl;

   logic        n_instReady, n_memRdEnable, n_memWrEnable, n_memUnsigned, n_mduStart;
   logic        n_regWrEnable, n_pcUpdate, n_trap;
   logic [1:0]  n_memAccess, n_operandASel, n_operandBSel, n_regWrDataSel, n_pcNextSel, n_trapCause;
   logic [3:0]  n_aluControl;
   logic [2:0]  n_mduControl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clock = ~i_clock;

   datapath_controller_mc #(.RV_EXT_M(1), .MEM_TIMEOUT(16), .MISALIGN_CHECK(1)) u_dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_inst(i_inst), .i_instValid(i_instValid),
      .o_instReady(o_instReady), .i_isEqual(i_isEqual), .i_isLessSigned(i_isLessSigned),
      .i_isLessUnsigned(i_isLessUnsigned), .i_addrLow(i_addrLow), .i_memReady(i_memReady),
      .i_mduDone(i_mduDone), .i_trapAck(i_trapAck), .o_memRdEnable(o_memRdEnable),
      .o_memWrEnable(o_memWrEnable), .o_memAccess(o_memAccess), .o_memUnsigned(o_memUnsigned),
      .o_aluControl(o_aluControl), .o_mduControl(o_mduControl), .o_mduStart(o_mduStart),
      .o_operandASel(o_operandASel), .o_operandBSel(o_operandBSel), .o_regWrEnable(o_regWrEnable),
      .o_regWrDataSel(o_regWrDataSel), .o_pcUpdate(o_pcUpdate), .o_pcNextSel(o_pcNextSel),
      .o_trap(o_trap), .o_trapCause(o_trapCause)
   );

   datapath_controller_mc #(.RV_EXT_M(0), .MEM_TIMEOUT(16), .MISALIGN_CHECK(1)) u_dut_nom (
      .i_clock(i_clock), .i_reset(i_reset), .i_inst(i_inst), .i_instValid(i_instValid),
      .o_instReady(n_instReady), .i_isEqual(i_isEqual), .i_isLessSigned(i_isLessSigned),
      .i_isLessUnsigned(i_isLessUnsigned), .i_addrLow(i_addrLow), .i_memReady(i_memReady),
      .i_mduDone(i_mduDone), .i_trapAck(i_trapAck), .o_memRdEnable(n_memRdEnable),
      .o_memWrEnable(n_memWrEnable), .o_memAccess(n_memAccess), .o_memUnsigned(n_memUnsigned),
      .o_aluControl(n_aluControl), .o_mduControl(n_mduControl), .o_mduStart(n_mduStart),
      .o_operandASel(n_operandASel), .o_operandBSel(n_operandBSel), .o_regWrEnable(n_regWrEnable),
      .o_regWrDataSel(n_regWrDataSel), .o_pcUpdate(n_pcUpdate), .o_pcNextSel(n_pcNextSel),
      .o_trap(n_trap), .o_trapCause(n_trapCause)
   );

   typedef struct {
      logic [31:0] inst;
      logic        eq, ls, lu;
      logic [1:0]  addrLow;
      logic [3:0]  alu;
      logic [1:0]  aSel, bSel;
      logic        regWr;
      logic [1:0]  wdSel;
      logic        pcUpd;
      logic [1:0]  pcSel;
      logic        trap;
      logic [1:0]  cause;
      logic        chkSel;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] inst, input logic eq, input logic ls, input logic lu,
                               input logic [1:0] al, input logic [3:0] alu, input logic [1:0] a,
                               input logic [1:0] b, input logic rw, input logic [1:0] wd,
                               input logic pu, input logic [1:0] ps, input logic tr,
                               input logic [1:0] cause, input logic cs);
      vec_t v;
      v.inst = inst; v.eq = eq; v.ls = ls; v.lu = lu; v.addrLow = al;
      v.alu = alu; v.aSel = a; v.bSel = b; v.regWr = rw; v.wdSel = wd;
      v.pcUpd = pu; v.pcSel = ps; v.trap = tr; v.cause = cause; v.chkSel = cs;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic offer(input logic [31:0] inst);
      @(negedge i_clock);
      i_inst = inst;
      i_instValid = 1'b1;
      #1 chk("offer ready", 32'(o_instReady), 32'd1);
      @(negedge i_clock);
      i_instValid = 1'b0;
   endtask

   task automatic ack_trap();
      i_trapAck = 1'b1;
      @(negedge i_clock);
      i_trapAck = 1'b0;
      #1 chk("ack ready", 32'(o_instReady), 32'd1);
      chk("ack ready nom", 32'(n_instReady), 32'd1);
   endtask

   initial begin
      // ALU / jump / branch (state returns to IDLE)
      vecs.push_back(mk(32'h002081B3, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 1));
      vecs.push_back(mk(32'h402081B3, 0,0,0, 2'b00, 4'b1000, 2'b00, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 1));
      vecs.push_back(mk(32'h00500093, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b01, 1, 2'b00, 1, 2'b00, 0, 0, 1));
      vecs.push_back(mk(32'h00713093, 0,0,0, 2'b00, 4'b0011, 2'b00, 2'b01, 1, 2'b00, 1, 2'b00, 0, 0, 1));
      vecs.push_back(mk(32'h123452B7, 0,0,0, 2'b00, 4'b0000, 2'b10, 2'b01, 1, 2'b00, 1, 2'b00, 0, 0, 1));
      vecs.push_back(mk(32'h00001297, 0,0,0, 2'b00, 4'b0000, 2'b01, 2'b01, 1, 2'b00, 1, 2'b00, 0, 0, 1));
      vecs.push_back(mk(32'h008000EF, 0,0,0, 2'b00, 4'b0000, 2'b01, 2'b01, 1, 2'b10, 1, 2'b01, 0, 0, 1));
      vecs.push_back(mk(32'h000100E7, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b01, 1, 2'b10, 1, 2'b11, 0, 0, 1));
      vecs.push_back(mk(32'h00208463, 1,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 1, 2'b01, 0, 0, 1));
      vecs.push_back(mk(32'h00208463, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 1, 2'b00, 0, 0, 1));
      vecs.push_back(mk(32'h00209463, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 1, 2'b01, 0, 0, 1));
      vecs.push_back(mk(32'h0020C463, 0,1,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 1, 2'b01, 0, 0, 1));
      vecs.push_back(mk(32'h0020D463, 0,1,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 1, 2'b00, 0, 0, 1));
      vecs.push_back(mk(32'h0020D463, 1,1,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 1, 2'b01, 0, 0, 1));
      vecs.push_back(mk(32'h0020F463, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 1, 2'b01, 0, 0, 1));
      vecs.push_back(mk(32'h0020E463, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 1, 2'b00, 0, 0, 1));
      // illegal encodings
      vecs.push_back(mk(32'h000110E7, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 1, 0, 0));
      vecs.push_back(mk(32'h0040B283, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 1, 0, 0));
      vecs.push_back(mk(32'h0020B023, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 1, 0, 0));
      vecs.push_back(mk(32'h402091B3, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 1, 0, 0));
      vecs.push_back(mk(32'h00000000, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 1, 0, 0));
      vecs.push_back(mk(32'h0020A463, 0,0,0, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 1, 0, 0));
      // misaligned SW / SH / LH
      vecs.push_back(mk(32'h0020A023, 0,0,0, 2'b10, 4'b0000, 2'b00, 2'b01, 0, 2'b00, 0, 2'b00, 1, 1, 1));
      vecs.push_back(mk(32'h00209023, 0,0,0, 2'b01, 4'b0000, 2'b00, 2'b01, 0, 2'b00, 0, 2'b00, 1, 1, 1));
      vecs.push_back(mk(32'h00409283, 0,0,0, 2'b11, 4'b0000, 2'b00, 2'b01, 0, 2'b00, 0, 2'b00, 1, 1, 1));

      // reset state
      @(negedge i_clock);
      #1;
      chk("rst ready", 32'(o_instReady), 32'd1);
      chk("rst regWr", 32'(o_regWrEnable), 32'd0);
      chk("rst pcUpd", 32'(o_pcUpdate), 32'd0);
      chk("rst trap", 32'(o_trap), 32'd0);
      chk("rst cause", 32'(o_trapCause), 32'd0);
      chk("rst alu", 32'(o_aluControl), 32'd0);
      chk("rst memRd", 32'(o_memRdEnable), 32'd0);
      chk("rst sels", 32'({o_operandASel, o_operandBSel, o_regWrDataSel, o_pcNextSel}), 32'd0);
      @(negedge i_clock);
      i_reset = 1'b0;

      foreach (vecs[i]) begin
         offer(vecs[i].inst);
         i_isEqual = vecs[i].eq; i_isLessSigned = vecs[i].ls;
         i_isLessUnsigned = vecs[i].lu; i_addrLow = vecs[i].addrLow;
         #1;
         chk($sformatf("v%0d regWr", i), 32'(o_regWrEnable), 32'(vecs[i].regWr));
         chk($sformatf("v%0d wdSel", i), 32'(o_regWrDataSel), 32'(vecs[i].wdSel));
         chk($sformatf("v%0d pcUpd", i), 32'(o_pcUpdate), 32'(vecs[i].pcUpd));
         chk($sformatf("v%0d pcSel", i), 32'(o_pcNextSel), 32'(vecs[i].pcSel));
         chk($sformatf("v%0d memEn", i), 32'({o_memRdEnable, o_memWrEnable, o_mduStart}), 32'd0);
         if (vecs[i].chkSel) begin
            chk($sformatf("v%0d alu", i), 32'(o_aluControl), 32'(vecs[i].alu));
            chk($sformatf("v%0d aSel", i), 32'(o_operandASel), 32'(vecs[i].aSel));
            chk($sformatf("v%0d bSel", i), 32'(o_operandBSel), 32'(vecs[i].bSel));
         end
         @(negedge i_clock);
         #1;
         chk($sformatf("v%0d trap", i), 32'(o_trap), 32'(vecs[i].trap));
         chk($sformatf("v%0d ready", i), 32'(o_instReady), 32'(!vecs[i].trap));
         if (vecs[i].trap) begin
            chk($sformatf("v%0d cause", i), 32'(o_trapCause), 32'(vecs[i].cause));
            chk($sformatf("v%0d trap quiet", i),
                32'({o_memWrEnable, o_memRdEnable, o_regWrEnable, o_pcUpdate}), 32'd0);
            ack_trap();
         end
         i_isEqual = 1'b0; i_isLessSigned = 1'b0; i_isLessUnsigned = 1'b0; i_addrLow = 2'b00;
      end

      // LW with 3 wait cycles
      offer(32'h0040A283);
      #1 chk("lw exec memRd", 32'(o_memRdEnable), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clock);
         i_memReady = (k == 3);
         #1;
         chk($sformatf("lw mem%0d rd", k), 32'(o_memRdEnable), 32'd1);
         chk($sformatf("lw mem%0d acc", k), 32'({o_memAccess, o_memUnsigned}), 32'b100);
         chk($sformatf("lw mem%0d regWr", k), 32'(o_regWrEnable), 32'd0);
      end
      @(negedge i_clock);
      i_memReady = 1'b0;
      #1;
      chk("lw wb regWr", 32'(o_regWrEnable), 32'd1);
      chk("lw wb sel", 32'(o_regWrDataSel), 32'd1);
      chk("lw wb pc", 32'({o_pcUpdate, o_pcNextSel}), 32'b100);
      chk("lw wb memRd", 32'(o_memRdEnable), 32'd0);
      @(negedge i_clock);
      #1;
      chk("lw done regWr", 32'(o_regWrEnable), 32'd0);
      chk("lw done ready", 32'(o_instReady), 32'd1);

      // SB with memReady held high from IDLE: completes in the first MEM cycle
      i_memReady = 1'b1;
      i_addrLow  = 2'b11;
      offer(32'h00208023);
      #1 chk("sb exec", 32'({o_memWrEnable, o_pcUpdate}), 32'd0);
      @(negedge i_clock);
      #1;
      chk("sb mem wr", 32'(o_memWrEnable), 32'd1);
      chk("sb mem acc", 32'(o_memAccess), 32'd0);
      chk("sb mem pc", 32'({o_pcUpdate, o_regWrEnable}), 32'b10);
      @(negedge i_clock);
      i_memReady = 1'b0;
      i_addrLow  = 2'b00;
      #1 chk("sb done", 32'({o_instReady, o_memWrEnable}), 32'b10);

      // MUL: MDU on the main instance, illegal on the RV_EXT_M=0 instance
      offer(32'h022081B3);
      #1;
      chk("mul start", 32'(o_mduStart), 32'd1);
      chk("mul ctl", 32'(o_mduControl), 32'd0);
      chk("mul nom start", 32'(n_mduStart), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         @(negedge i_clock);
         i_mduDone = (k == 10);
         #1;
         chk($sformatf("mdu%0d start", k), 32'(o_mduStart), 32'd0);
         chk($sformatf("mdu%0d regWr", k), 32'(o_regWrEnable), 32'd0);
         if (k == 1) begin
            chk("mul nom trap", 32'(n_trap), 32'd1);
            chk("mul nom cause", 32'(n_trapCause), 32'd0);
         end
      end
      @(negedge i_clock);
      i_mduDone = 1'b0;
      #1;
      chk("mul wb", 32'({o_regWrEnable, o_regWrDataSel, o_pcUpdate}), 32'b1111);
      @(negedge i_clock);
      #1 chk("mul done ready", 32'(o_instReady), 32'd1);
      ack_trap();

      // LW timeout
      offer(32'h0040A283);
      begin
         int cnt;
         cnt = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge i_clock);
            #1;
            if (o_memRdEnable) cnt++;
            else break;
         end
         chk("tmo mem cycles", 32'(cnt), 32'd16);
      end
      chk("tmo trap", 32'(o_trap), 32'd1);
      chk("tmo cause", 32'(o_trapCause), 32'd2);
      ack_trap();

      // reset asserted mid-MEM
      offer(32'h0040A283);
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clock);
         #1 chk($sformatf("rmem%0d rd", k), 32'(o_memRdEnable), 32'd1);
      end
      @(negedge i_clock);
      i_reset = 1'b1;
      #1;
      chk("rmid memRd", 32'(o_memRdEnable), 32'd0);
      chk("rmid wr/pc", 32'({o_regWrEnable, o_pcUpdate}), 32'd0);
      chk("rmid ready", 32'(o_instReady), 32'd1);
      @(negedge i_clock);
      i_reset = 1'b0;
      i_memReady = 1'b1;
      #1 chk("rmid after", 32'({o_regWrEnable, o_memRdEnable, o_instReady}), 32'b001);
      @(negedge i_clock);
      i_memReady = 1'b0;
      #1 chk("rmid idle", 32'({o_regWrEnable, o_instReady}), 32'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
